tdp_ram_arbiter: RTL and testbench

Round-robin arbiter that shares one single-clock true-dual-port RAM between NREQ requesters. Each cycle it grants up to two requests, one on RAM port A and one on port B, and rejects a port-B pairing that would collide on an address. It routes 1-cycle read data back to the requester that issued the read. It sits between client engines and an external TDP RAM running in NO_CHANGE mode with registered outputs.

---
 rtl/tdp_ram_arbiter_pkg.sv | 19 +
 rtl/tdp_ram_arbiter_rr_pick.sv | 33 +++
 rtl/tdp_ram_arbiter.sv | 122 ++++++++++++
 tb/tb_tdp_ram_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tdp_ram_arbiter_pkg.sv
// Shared sizing helpers and port indices for the TDP RAM arbiter.
// Latency: none (package only).
// Backpressure: none (package only).
package tdp_ram_arbiter_pkg;

   localparam int PORT_A = 0;
   localparam int PORT_B = 1;

   // Address width for a RAM of the given depth (never less than 1 bit)
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Width of a requester index (never less than 1 bit)
   function automatic int idx_w(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

endpackage

// File: rtl/tdp_ram_arbiter_rr_pick.sv
// Circular priority finder: first set mask bit at or after start, wrapping.
// Latency: purely combinational.
// Backpressure: none; result follows inputs in the same cycle.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] start,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   int             off;

   // rotate so start sits at bit 0, then take the lowest set bit
   always_comb begin
      dbl   = {mask, mask} >> start;
      rot   = dbl[N-1:0];
      found = 1'b0;
      off   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            found = 1'b1;
            off   = k;
         end
      end
      idx = IW'((int'(start) + off) % N);
   end

endmodule

// File: rtl/tdp_ram_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto a TDP RAM.
// Latency: 0-cycle grant, read data returned 1 cycle after the accepting edge.
// Backpressure: req_ready only for selected requesters; responses cannot stall.
module tdp_ram_arbiter
   import tdp_ram_arbiter_pkg::*;
#(
   parameter int  NREQ  = 4,
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 256,
   localparam int AW    = addr_w(DEPTH),
   localparam int IW    = idx_w(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ-1:0]       req_we,
   input  logic [NREQ*AW-1:0]    req_addr,
   input  logic [NREQ*WIDTH-1:0] req_wdata,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [NREQ*WIDTH-1:0] rsp_data,
   output logic                  ram_ena,
   output logic                  ram_wea,
   output logic [AW-1:0]         ram_addra,
   output logic [WIDTH-1:0]      ram_dina,
   output logic                  ram_enb,
   output logic                  ram_web,
   output logic [AW-1:0]         ram_addrb,
   output logic [WIDTH-1:0]      ram_dinb,
   input  logic [WIDTH-1:0]      ram_douta,
   input  logic [WIDTH-1:0]      ram_doutb
);

   logic [IW-1:0]   ptr;
   logic [1:0]      pend;
   logic [IW-1:0]   tag [2];

   logic            a_found, b_found, a_gnt, b_gnt;
   logic [IW-1:0]   ga, gb, b_start;
   logic [AW-1:0]   addr_ga;
   logic [NREQ-1:0] collide, ga_oh, b_mask;

   rr_pick #(.N(NREQ), .IW(IW)) u_pick_a (
      .mask  (req_valid),
      .start (ptr),
      .found (a_found),
      .idx   (ga)
   );

   // port B candidates: everyone but ga, minus anything that collides with ga
   always_comb begin
      addr_ga = req_addr[ga*AW +: AW];
      ga_oh   = '0;
      ga_oh[ga] = 1'b1;
      collide = '0;
      for (int j = 0; j < NREQ; j++) begin
         collide[j] = (req_addr[j*AW +: AW] == addr_ga) && (req_we[j] || req_we[ga]);
      end
      b_mask  = req_valid & ~ga_oh & ~collide;
      b_start = IW'((int'(ga) + 1) % NREQ);
   end

   rr_pick #(.N(NREQ), .IW(IW)) u_pick_b (
      .mask  (b_mask),
      .start (b_start),
      .found (b_found),
      .idx   (gb)
   );

   // grants and RAM controls; reset gates everything off combinationally
   always_comb begin
      a_gnt     = a_found && !rst;
      b_gnt     = b_found && !rst;
      req_ready = '0;
      if (a_gnt) req_ready[ga] = 1'b1;
      if (b_gnt) req_ready[gb] = 1'b1;
      ram_ena   = a_gnt;
      ram_wea   = a_gnt && req_we[ga];
      ram_addra = a_gnt ? req_addr[ga*AW +: AW] : '0;
      ram_dina  = a_gnt ? req_wdata[ga*WIDTH +: WIDTH] : '0;
      ram_enb   = b_gnt;
      ram_web   = b_gnt && req_we[gb];
      ram_addrb = b_gnt ? req_addr[gb*AW +: AW] : '0;
      ram_dinb  = b_gnt ? req_wdata[gb*WIDTH +: WIDTH] : '0;
   end

   // advance pointer past the last grant and remember which reads are in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr         <= '0;
         pend        <= '0;
         tag[PORT_A] <= '0;
         tag[PORT_B] <= '0;
      end else begin
         if (b_gnt) begin
            ptr <= IW'((int'(gb) + 1) % NREQ);
         end else if (a_gnt) begin
            ptr <= b_start;
         end
         pend[PORT_A] <= a_gnt && !req_we[ga];
         pend[PORT_B] <= b_gnt && !req_we[gb];
         tag[PORT_A]  <= ga;
         tag[PORT_B]  <= gb;
      end
   end

   // steer registered RAM outputs back to the requester that issued the read
   always_comb begin
      logic hit_a, hit_b;
      rsp_valid = '0;
      rsp_data  = '0;
      hit_a     = 1'b0;
      hit_b     = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         hit_a = pend[PORT_A] && (tag[PORT_A] == IW'(i));
         hit_b = pend[PORT_B] && (tag[PORT_B] == IW'(i));
         rsp_valid[i] = hit_a || hit_b;
         rsp_data[i*WIDTH +: WIDTH] = hit_a ? ram_douta : ram_doutb;
      end
   end

endmodule

// File: tb/tb_tdp_ram_arbiter.sv
// Self-checking bench for tdp_ram_arbiter with a behavioural RAM and reference model.
// Latency: checks 0-cycle grants and 1-cycle read returns.
// Backpressure: responses are always sunk by the bench.
module tb_tdp_ram_arbiter;
   import tdp_ram_arbiter_pkg::*;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int DEPTH = 256;
   localparam int AW    = addr_w(DEPTH);

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  tb_init;
   logic [NREQ-1:0]       req_valid, req_ready, req_we, rsp_valid;
   logic [NREQ*AW-1:0]    req_addr;
   logic [NREQ*WIDTH-1:0] req_wdata, rsp_data;
   logic                  ram_ena, ram_wea, ram_enb, ram_web;
   logic [AW-1:0]         ram_addra, ram_addrb;
   logic [WIDTH-1:0]      ram_dina, ram_dinb, ram_douta, ram_doutb;

   logic [WIDTH-1:0]      ram_mem [DEPTH];

   int                    vectors = 0;
   int                    miscompares = 0;
   int                    m_ptr;
   logic [WIDTH-1:0]      m_mem [DEPTH];
   logic [NREQ-1:0]       exp_rv;
   logic [WIDTH-1:0]      exp_rd [NREQ];

   always #5 clk = ~clk;

   tdp_ram_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
      .ram_enb(ram_enb), .ram_web(ram_web), .ram_addrb(ram_addrb), .ram_dinb(ram_dinb),
      .ram_douta(ram_douta), .ram_doutb(ram_doutb)
   );

   // external TDP RAM, NO_CHANGE mode, registered outputs
   always @(posedge clk) begin
      if (tb_init) begin
         for (int k = 0; k < DEPTH; k++) ram_mem[k] <= WIDTH'(k * 37 + 5);
         ram_douta <= '0;
         ram_doutb <= '0;
      end else begin
         if (ram_ena) begin
            if (ram_wea) ram_mem[ram_addra] <= ram_dina;
            else         ram_douta <= ram_mem[ram_addra];
         end
         if (ram_enb) begin
            if (ram_web) ram_mem[ram_addrb] <= ram_dinb;
            else         ram_doutb <= ram_mem[ram_addrb];
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] a_of(input int i);
      return req_addr[i*AW +: AW];
   endfunction

   function automatic logic [WIDTH-1:0] d_of(input int i);
      return req_wdata[i*WIDTH +: WIDTH];
   endfunction

   task automatic clear_reqs();
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
   endtask

   task automatic set_req(input int i, input logic v, input logic we,
                          input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      req_valid[i] = v;
      req_we[i]    = we;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*WIDTH +: WIDTH] = d;
   endtask

   // reference grant rules: A = first valid from ptr, B = first non-colliding after A
   task automatic model_grants(input int ptr, output int ga, output int gb);
      int i;
      ga = -1;
      gb = -1;
      for (int k = 0; k < NREQ; k++) begin
         i = (ptr + k) % NREQ;
         if (ga < 0 && req_valid[i]) ga = i;
      end
      if (ga >= 0) begin
         for (int k = 1; k < NREQ; k++) begin
            i = (ga + k) % NREQ;
            if (gb < 0 && req_valid[i] &&
                !(a_of(i) == a_of(ga) && (req_we[i] || req_we[ga]))) gb = i;
         end
      end
   endtask

   // called just after a falling edge with inputs applied; returns at the next falling edge
   task automatic run_cycle();
      int ga, gb;
      logic [NREQ-1:0]  want_rdy, new_rv;
      logic [WIDTH-1:0] new_rd [NREQ];
      #1;
      model_grants(m_ptr, ga, gb);
      want_rdy = '0;
      if (ga >= 0) want_rdy[ga] = 1'b1;
      if (gb >= 0) want_rdy[gb] = 1'b1;
      chk("req_ready", req_ready, want_rdy);
      chk("ram_ena", ram_ena, ga >= 0);
      chk("ram_enb", ram_enb, gb >= 0);
      chk("ram_wea", ram_wea, (ga >= 0) ? req_we[ga] : 1'b0);
      chk("ram_web", ram_web, (gb >= 0) ? req_we[gb] : 1'b0);
      chk("ram_addra", ram_addra, (ga >= 0) ? a_of(ga) : '0);
      chk("ram_addrb", ram_addrb, (gb >= 0) ? a_of(gb) : '0);
      chk("ram_dina", ram_dina, (ga >= 0) ? d_of(ga) : '0);
      chk("ram_dinb", ram_dinb, (gb >= 0) ? d_of(gb) : '0);
      chk("rsp_valid", rsp_valid, exp_rv);
      for (int i = 0; i < NREQ; i++) begin
         if (exp_rv[i]) chk($sformatf("rsp_data%0d", i), rsp_data[i*WIDTH +: WIDTH], exp_rd[i]);
      end
      @(posedge clk);
      new_rv = '0;
      for (int i = 0; i < NREQ; i++) new_rd[i] = '0;
      if (ga >= 0 && !req_we[ga]) begin new_rv[ga] = 1'b1; new_rd[ga] = m_mem[a_of(ga)]; end
      if (gb >= 0 && !req_we[gb]) begin new_rv[gb] = 1'b1; new_rd[gb] = m_mem[a_of(gb)]; end
      if (ga >= 0 && req_we[ga]) m_mem[a_of(ga)] = d_of(ga);
      if (gb >= 0 && req_we[gb]) m_mem[a_of(gb)] = d_of(gb);
      if (gb >= 0)      m_ptr = (gb + 1) % NREQ;
      else if (ga >= 0) m_ptr = (ga + 1) % NREQ;
      exp_rv = new_rv;
      for (int i = 0; i < NREQ; i++) exp_rd[i] = new_rd[i];
      @(negedge clk);
   endtask

   initial begin
      logic [NREQ-1:0] want;
      for (int k = 0; k < DEPTH; k++) m_mem[k] = WIDTH'(k * 37 + 5);
      m_ptr   = 0;
      exp_rv  = '0;
      for (int i = 0; i < NREQ; i++) exp_rd[i] = '0;
      rst     = 1'b1;
      tb_init = 1'b1;
      clear_reqs();

      // reset state with idle inputs
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_ready", req_ready, 4'b0000);
      chk("rst_rsp_valid", rsp_valid, 4'b0000);
      chk("rst_ena", ram_ena, 1'b0);
      chk("rst_enb", ram_enb, 1'b0);
      chk("rst_addra", ram_addra, 8'h00);
      chk("rst_addrb", ram_addrb, 8'h00);
      // requests during reset are not granted
      set_req(0, 1'b1, 1'b0, 8'd1, 8'h00);
      set_req(1, 1'b1, 1'b0, 8'd2, 8'h00);
      #1;
      chk("rst_gated_ready", req_ready, 4'b0000);
      chk("rst_gated_ena", ram_ena, 1'b0);
      clear_reqs();
      @(negedge clk);
      rst     = 1'b0;
      tb_init = 1'b0;
      run_cycle();

      // write vs read on the same address: only the writer is granted
      set_req(1, 1'b1, 1'b1, 8'd7, 8'hAA);
      set_req(3, 1'b1, 1'b0, 8'd7, 8'h00);
      #1;
      chk("wr_collide_ready", req_ready, 4'b0010);
      run_cycle();
      clear_reqs();
      set_req(3, 1'b1, 1'b0, 8'd7, 8'h00);
      #1;
      chk("rd_after_wr_ready", req_ready, 4'b1000);
      run_cycle();

      // two reads on distinct addresses split across ports
      clear_reqs();
      set_req(0, 1'b1, 1'b0, 8'd5, 8'h00);
      set_req(2, 1'b1, 1'b0, 8'd9, 8'h00);
      #1;
      chk("rd_after_wr_valid", rsp_valid, 4'b1000);
      chk("rd_after_wr_data", rsp_data[3*WIDTH +: WIDTH], 8'hAA);
      chk("pair_ready", req_ready, 4'b0101);
      chk("pair_addra", ram_addra, 8'd5);
      chk("pair_addrb", ram_addrb, 8'd9);
      run_cycle();

      // two reads on the same address are both granted
      clear_reqs();
      set_req(0, 1'b1, 1'b0, 8'd3, 8'h00);
      set_req(1, 1'b1, 1'b0, 8'd3, 8'h00);
      #1;
      chk("pair_rsp_valid", rsp_valid, 4'b0101);
      chk("same_rd_ready", req_ready, 4'b0011);
      run_cycle();
      clear_reqs();
      #1;
      chk("same_rd_rsp_valid", rsp_valid, 4'b0011);
      run_cycle();

      // reset lands between grant and accepting edge: read is dropped
      clear_reqs();
      set_req(2, 1'b1, 1'b0, 8'd10, 8'h00);
      #1;
      chk("pre_rst_ready", req_ready, 4'b0100);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", req_ready, 4'b0000);
      chk("mid_rst_ena", ram_ena, 1'b0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("mid_rst_rsp_valid", rsp_valid, 4'b0000);
      rst    = 1'b0;
      m_ptr  = 0;
      exp_rv = '0;

      // all four reading continuously: pairs (0,1),(2,3) alternate
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, AW'(20 + i), 8'h00);
         want = (k % 2 == 0) ? 4'b0011 : 4'b1100;
         #1;
         chk($sformatf("all4_ready%0d", k), req_ready, want);
         run_cycle();
      end

      // randomized traffic with a small address range to force collisions
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                    AW'($urandom_range(0, 7)), WIDTH'($urandom));
         end
         run_cycle();
      end
      clear_reqs();
      run_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
